// File: rtl/skolem_pkg.sv
// Shared types and elaboration helpers for the serial parity Skolem evaluator.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package skolem_pkg;

    // Upper bound on beat width that last_mask can describe.
    localparam int MAX_LANE_W = 256;

    typedef enum logic {
        ACCUM = 1'b0,
        OUT   = 1'b1
    } skolem_state_e;

    // Number of beats needed to carry n_in bits, lane_w bits at a time.
    function automatic int calc_beats(input int n_in, input int lane_w);
        if (lane_w < 1) begin
            return 1;
        end
        return (n_in + lane_w - 1) / lane_w;
    endfunction

    // Valid-bit mask for the final beat; bits past the end of the vector are cleared.
    function automatic logic [MAX_LANE_W-1:0] last_mask(input int n_in, input int lane_w);
        int                    last_bits;
        logic [MAX_LANE_W-1:0] m;
        last_bits = n_in - (calc_beats(n_in, lane_w) - 1) * lane_w;
        m = '0;
        for (int i = 0; i < MAX_LANE_W; i++) begin
            if (i < last_bits) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/lane_parity_reduce.sv
// Parity of one beat after masking off bits that are not part of the vector.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module lane_parity_reduce #(
    parameter int LANE_W = 4
) (
    input  logic [LANE_W-1:0] data,
    input  logic [LANE_W-1:0] mask,
    output logic              parity
);

    assign parity = ^(data & mask);

endmodule

// File: rtl/parity_skolem_stream.sv
// Serial XNOR/XOR Skolem evaluator over LANE_W-bit beats; optional candidate check under SKOLEM_CAND_CHECK_EN.
// Latency: out_valid rises the cycle after the final beat is accepted; one vector per BEATS+1 cycles.
// Backpressure: in_ready drops while a result is held; result and out_y stay put until out_ready.
module parity_skolem_stream
    import skolem_pkg::*;
#(
    parameter int N_IN   = 7,
    parameter int LANE_W = 4,
    parameter int INVERT = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LANE_W-1:0] in_data,
`ifdef SKOLEM_CAND_CHECK_EN
    input  logic              in_cand,
    output logic              out_mismatch,
    output logic [CNT_W-1:0]  err_cnt,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_y,
    output logic [CNT_W-1:0]  out_cnt
);

    localparam int BEATS  = calc_beats(N_IN, LANE_W);
    localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [LANE_W-1:0] LAST_MASK = LANE_W'(last_mask(N_IN, LANE_W));
    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);
    localparam logic INVERT_B = (INVERT != 0);

    // Refuse to build with a beat wider than the vector or an empty vector.
    if (N_IN < 1 || LANE_W < 1 || LANE_W > N_IN || LANE_W > MAX_LANE_W) begin : g_bad_params
        $error("parity_skolem_stream: invalid N_IN/LANE_W combination");
    end

    skolem_state_e     state;
    logic              acc;
    logic [BCNT_W-1:0] beat_cnt;
    logic              is_last;
    logic [LANE_W-1:0] beat_mask;
    logic              beat_par;
    logic              y_next;

    // Only the final beat of a vector can carry padding bits.
    assign is_last   = (beat_cnt == LAST_BEAT);
    assign beat_mask = is_last ? LAST_MASK : '1;
    assign y_next    = acc ^ beat_par ^ INVERT_B;

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == OUT);

    lane_parity_reduce #(
        .LANE_W (LANE_W)
    ) u_reduce (
        .data   (in_data),
        .mask   (beat_mask),
        .parity (beat_par)
    );

    // FSM: fold beat parities into acc, then present one result until it is consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ACCUM;
            acc      <= 1'b0;
            beat_cnt <= '0;
            out_y    <= 1'b0;
            out_cnt  <= '0;
`ifdef SKOLEM_CAND_CHECK_EN
            out_mismatch <= 1'b0;
            err_cnt      <= '0;
`endif
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        if (is_last) begin
                            out_y    <= y_next;
                            acc      <= 1'b0;
                            beat_cnt <= '0;
                            state    <= OUT;
`ifdef SKOLEM_CAND_CHECK_EN
                            out_mismatch <= in_cand ^ y_next;
`endif
                        end else begin
                            acc      <= acc ^ beat_par;
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                OUT: begin
                    // No bypass: a beat offered in this cycle waits for ACCUM.
                    if (out_ready) begin
                        if (out_cnt != '1) begin
                            out_cnt <= out_cnt + 1'b1;
                        end
`ifdef SKOLEM_CAND_CHECK_EN
                        if (out_mismatch && (err_cnt != '1)) begin
                            err_cnt <= err_cnt + 1'b1;
                        end
`endif
                        state <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_parity_skolem_stream.sv
// Bench for parity_skolem_stream: default 7/4 XNOR instance plus an 8/8 XOR instance with a 2-bit counter.
// Latency: expects results one cycle after the final beat; checks hold under backpressure.
// Backpressure: drives out_ready stalls and offers beats while a result is pending.
module tb_parity_skolem_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: N_IN=7, LANE_W=4, INVERT=1, CNT_W=16
    logic        a_in_valid = 1'b0;
    logic        a_in_ready;
    logic [3:0]  a_in_data  = 4'h0;
    logic        a_out_valid;
    logic        a_out_ready = 1'b0;
    logic        a_out_y;
    logic [15:0] a_out_cnt;
`ifdef SKOLEM_CAND_CHECK_EN
    logic        a_in_cand = 1'b0;
    logic        a_out_mismatch;
    logic [15:0] a_err_cnt;
    logic        b_in_cand = 1'b0;
    logic        b_out_mismatch;
    logic [1:0]  b_err_cnt;
`endif

    // Instance B: N_IN=8, LANE_W=8, INVERT=0, CNT_W=2
    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [7:0]  b_in_data  = 8'h0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b0;
    logic        b_out_y;
    logic [1:0]  b_out_cnt;

    parity_skolem_stream u_dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (a_in_valid),
        .in_ready     (a_in_ready),
        .in_data      (a_in_data),
`ifdef SKOLEM_CAND_CHECK_EN
        .in_cand      (a_in_cand),
        .out_mismatch (a_out_mismatch),
        .err_cnt      (a_err_cnt),
`endif
        .out_valid    (a_out_valid),
        .out_ready    (a_out_ready),
        .out_y        (a_out_y),
        .out_cnt      (a_out_cnt)
    );

    parity_skolem_stream #(
        .N_IN   (8),
        .LANE_W (8),
        .INVERT (0),
        .CNT_W  (2)
    ) u_dut_b (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (b_in_valid),
        .in_ready     (b_in_ready),
        .in_data      (b_in_data),
`ifdef SKOLEM_CAND_CHECK_EN
        .in_cand      (b_in_cand),
        .out_mismatch (b_out_mismatch),
        .err_cnt      (b_err_cnt),
`endif
        .out_valid    (b_out_valid),
        .out_ready    (b_out_ready),
        .out_y        (b_out_y),
        .out_cnt      (b_out_cnt)
    );

    int checks   = 0;
    int failures = 0;
    int a_cnt    = 0;   // results consumed from A since reset
    int a_err    = 0;   // consumed A results whose candidate disagreed
    int b_cnt    = 0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: parity of the first n bits by counting ones, optionally inverted.
    function automatic logic ref_y(input logic [31:0] x, input int n, input int inv);
        int ones;
        ones = 0;
        for (int i = 0; i < n; i++) begin
            ones += int'(x[i]);
        end
        return ((ones % 2) == 1) != (inv != 0);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        a_in_valid = 1'b0;
        a_out_ready = 1'b0;
        b_in_valid = 1'b0;
        b_out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        a_cnt = 0;
        a_err = 0;
        b_cnt = 0;
    endtask

    // Offer one beat to A at a negedge and hold it until a rising edge takes it.
    task automatic a_send(input logic [3:0] d, input logic cand, input int stall, input string tag);
        int t;
        repeat (stall) @(negedge clk);
        a_in_valid = 1'b1;
        a_in_data  = d;
`ifdef SKOLEM_CAND_CHECK_EN
        a_in_cand  = cand;
`endif
        t = 0;
        while (!a_in_ready && t < 16) begin
            @(negedge clk);
            t++;
        end
        if (t == 16) chk1({tag, ":rdy_timeout"}, a_in_ready, 1'b1);
        @(negedge clk);
        a_in_valid = 1'b0;
        a_in_data  = 4'($urandom);
    endtask

    // One full vector through A: two beats, a result check, hold cycles, then consume.
    task automatic a_run(input logic [3:0] d0, input logic [3:0] d1, input logic exp_y,
                         input logic cand, input int stall, input int hold, input string tag);
        a_send(d0, 1'b0, stall, tag);
        chk1({tag, ":partial_vld"}, a_out_valid, 1'b0);
        chk1({tag, ":partial_rdy"}, a_in_ready, 1'b1);
        a_send(d1, cand, stall, tag);
        chk1({tag, ":vld"}, a_out_valid, 1'b1);
        chk1({tag, ":y"}, a_out_y, exp_y);
`ifdef SKOLEM_CAND_CHECK_EN
        chk1({tag, ":mis"}, a_out_mismatch, cand ^ exp_y);
`endif
        for (int i = 0; i < hold; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 4'($urandom);
            @(negedge clk);
            chk1({tag, ":hold_vld"}, a_out_valid, 1'b1);
            chk1({tag, ":hold_y"}, a_out_y, exp_y);
            chk1({tag, ":hold_rdy"}, a_in_ready, 1'b0);
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
        a_cnt++;
        if (cand != exp_y) a_err++;
        chk1({tag, ":done_vld"}, a_out_valid, 1'b0);
        chk1({tag, ":done_rdy"}, a_in_ready, 1'b1);
        chkn({tag, ":cnt"}, a_out_cnt, 16'(a_cnt));
`ifdef SKOLEM_CAND_CHECK_EN
        chkn({tag, ":err"}, a_err_cnt, 16'(a_err));
`endif
    endtask

    // One single-beat vector through B, checking the OUT cycle and saturating count.
    task automatic b_run(input logic [7:0] d, input logic exp_y, input string tag);
        int t;
        b_in_valid = 1'b1;
        b_in_data  = d;
        t = 0;
        while (!b_in_ready && t < 16) begin
            @(negedge clk);
            t++;
        end
        if (t == 16) chk1({tag, ":rdy_timeout"}, b_in_ready, 1'b1);
        @(negedge clk);
        chk1({tag, ":vld"}, b_out_valid, 1'b1);
        chk1({tag, ":y"}, b_out_y, exp_y);
        chk1({tag, ":out_rdy_low"}, b_in_ready, 1'b0);
        b_in_data   = 8'($urandom);
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;
        b_in_valid  = 1'b0;
        b_cnt++;
        chk1({tag, ":done_vld"}, b_out_valid, 1'b0);
        chk1({tag, ":done_rdy"}, b_in_ready, 1'b1);
        chkn({tag, ":cnt"}, 16'(b_out_cnt), 16'((b_cnt > 3) ? 3 : b_cnt));
    endtask

    initial begin
        logic [6:0] xa;
        logic [7:0] xb;
        logic       cand;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk1("rst_a_vld", a_out_valid, 1'b0);
        chk1("rst_a_rdy", a_in_ready, 1'b1);
        chk1("rst_a_y", a_out_y, 1'b0);
        chkn("rst_a_cnt", a_out_cnt, 16'd0);
        chk1("rst_b_vld", b_out_valid, 1'b0);
        chkn("rst_b_cnt", 16'(b_out_cnt), 16'd0);

        // x=1010011: popcount 4, XNOR gives 1; candidate 0 disagrees
        a_run(4'h3, 4'h5, 1'b1, 1'b0, 0, 0, "vec_1010011");
        // Same vector with bit 3 of the last beat set: must be masked
        a_run(4'h3, 4'hD, 1'b1, 1'b1, 0, 0, "vec_masked");
        // x=0000001: popcount 1
        a_run(4'h1, 4'h0, 1'b0, 1'b0, 0, 0, "vec_0000001");
        // Backpressure: five stalled cycles with beats offered and refused (popcount 3)
        a_run(4'h6, 4'h2, 1'b0, 1'b0, 0, 5, "backpressure");
        // Follow-up vector proves no refused beat slipped into the accumulator
        a_run(4'h0, 4'h1, 1'b0, 1'b0, 1, 0, "after_bp");

        // Reset while a result is pending
        a_send(4'h0, 1'b0, 0, "pend");
        a_send(4'h0, 1'b1, 0, "pend");
        chk1("pend_vld", a_out_valid, 1'b1);
        do_reset();
        chk1("rst_out_vld", a_out_valid, 1'b0);
        chk1("rst_out_y", a_out_y, 1'b0);
        chkn("rst_out_cnt", a_out_cnt, 16'd0);

        // Reset mid-vector: partial beat 0x3 is discarded
        a_send(4'h3, 1'b0, 0, "mid3");
        do_reset();
        chk1("mid3_vld", a_out_valid, 1'b0);
        chkn("mid3_cnt", a_out_cnt, 16'd0);
        a_run(4'h0, 4'h0, 1'b1, 1'b1, 0, 0, "mid3_after");
        // Odd partial beat: a stale accumulator would flip the result
        a_send(4'h1, 1'b0, 0, "mid1");
        do_reset();
        a_run(4'h0, 4'h0, 1'b1, 1'b1, 0, 0, "mid1_after");

        // Randomized vectors against the popcount model, with stalls and holds
        for (int n = 0; n < 40; n++) begin
            xa   = 7'($urandom);
            cand = 1'($urandom);
            a_run(xa[3:0], {1'($urandom), xa[6:4]}, ref_y(32'(xa), 7, 1), cand,
                  $urandom_range(0, 2), $urandom_range(0, 3), "rand_a");
        end

        // Instance B: single-beat XOR vectors; counter saturates at 3
        b_run(8'hFF, 1'b0, "b_ff");
        b_run(8'h80, 1'b1, "b_80");
        for (int n = 0; n < 6; n++) begin
            xb = 8'($urandom);
            b_run(xb, ref_y(32'(xb), 8, 0), "rand_b");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
